uart_rx_param: RTL and testbench

//  Parametrised UART receiver: next-generation serial input for the SoC debug/loader path.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_rx_param.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
//   PAR_*       parity mode encodings for the PARITY parameter
//   rx_state_t  receive FSM states
//   calc_div    clock cycles per oversample tick, rounded to nearest
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Nearest-integer divide of the clock down to the oversample tick rate.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned tick_rate;
        tick_rate = baud * oversample;
        return (clk_freq + tick_rate / 2) / tick_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with full/empty flags.
//   clk, rst_n  clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata write request and word; ignored when full unless popping too
//   pop         read request; head advances when non-empty
//   rdata       head word (valid while !empty)
//   full, empty occupancy flags
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Extra pointer MSB tells full (MSBs differ) from empty (pointers equal).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the head slot this cycle, so a simultaneous push may use it.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign rdata = mem[rd_ptr[AW-1:0]];

    // Storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '{default: '0};
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with oversampling and a receive FIFO.
//   clk, rst_n   system clock, asynchronous active-low reset
//   rxd          serial line (idle high), asynchronous to clk
//   rx_data      head-of-FIFO data word
//   rx_perr      parity error of the head word
//   rx_ferr      framing error of the head word
//   rx_valid     FIFO non-empty
//   rx_ready     consumer accepts the head word when rx_valid && rx_ready
//   overrun      sticky: a frame arrived while the FIFO was full
//   overrun_clr  single-cycle clear of overrun
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam int unsigned FW    = DATA_BITS + 2;

    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic                 rxd_meta;
    logic                 rxd_s;

    rx_state_t            state,   state_d;
    logic [OS_W-1:0]      cnt,     cnt_d;
    logic [BIT_W-1:0]     bit_cnt, bit_d;
    logic [DATA_BITS-1:0] shreg,   shreg_d;
    logic                 perr,    perr_d;
    logic                 ferr,    ferr_d;
    logic                 push_c;
    logic                 mid;

    logic [FW-1:0]        fifo_wdata;
    logic [FW-1:0]        fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    // Free-running oversample tick generator.
    assign tick = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_cnt <= bit_d;
            shreg   <= shreg_d;
            perr    <= perr_d;
            ferr    <= ferr_d;
        end
    end

    // Mid-bit point once the counter is aligned to the start-bit centre.
    assign mid = (cnt == OS_W'(OVERSAMPLE - 1));

    // Next-state and datapath logic; everything advances on ticks only.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bit_d   = bit_cnt;
        shreg_d = shreg;
        perr_d  = perr;
        ferr_d  = ferr;
        push_c  = 1'b0;

        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        cnt_d   = '0;
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == OS_W'(OVERSAMPLE / 2 - 1)) begin
                        if (rxd_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d   = '0;
                            bit_d   = '0;
                            perr_d  = 1'b0;
                            ferr_d  = 1'b0;
                            state_d = ST_DATA;
                        end
                    end else begin
                        cnt_d = cnt + OS_W'(1);
                    end
                end
                ST_DATA: begin
                    if (mid) begin
                        cnt_d   = '0;
                        shreg_d = {rxd_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            bit_d   = '0;
                            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt + OS_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (mid) begin
                        cnt_d   = '0;
                        perr_d  = ((^shreg) ^ rxd_s) != (PARITY == PAR_ODD);
                        state_d = ST_STOP;
                    end else begin
                        cnt_d = cnt + OS_W'(1);
                    end
                end
                ST_STOP: begin
                    if (mid) begin
                        cnt_d  = '0;
                        ferr_d = ferr | ~rxd_s;
                        if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                            bit_d   = '0;
                            push_c  = 1'b1;
                            // A low stop bit may be a break; wait for idle first.
                            state_d = ferr_d ? ST_BREAK : ST_IDLE;
                        end else begin
                            bit_d = bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt + OS_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (rxd_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign fifo_wdata = {shreg, perr, ferr_d};
    assign pop        = rx_valid && rx_ready;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx_valid = !fifo_empty;
    assign rx_data  = fifo_rdata[FW-1:2];
    assign rx_perr  = fifo_rdata[1];
    assign rx_ferr  = fifo_rdata[0];

    // Sticky overrun; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (push_c && fifo_full && !pop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8E2 frames at a fast tick rate.
module tb_uart_rx_param;

    localparam int unsigned CLK_FREQ = 4_800_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned OS       = 16;
    localparam int unsigned DB       = 8;
    localparam int unsigned PAR      = 2;
    localparam int unsigned SB       = 2;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned DIV      = (CLK_FREQ + BAUD * OS / 2) / (BAUD * OS);
    localparam int unsigned BIT_CLK  = DIV * OS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rxd;
    logic [DB-1:0] rx_data;
    logic          rx_perr;
    logic          rx_ferr;
    logic          rx_valid;
    logic          rx_ready;
    logic          overrun;
    logic          overrun_clr;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [9:0]    exp_q[$];
    bit            exp_ovr = 1'b0;
    int            ready_mode = 0;
    int            cyc = 0;
    int            rise_cyc = -1;
    int            n_pops = 0;
    bit            prev_valid = 1'b0;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB),
        .PARITY     (PAR),
        .STOP_BITS  (SB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_perr     (rx_perr),
        .rx_ferr     (rx_ferr),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Reference: word the receiver should report for a frame as sent on the line.
    function automatic logic [9:0] model_word(input logic [7:0] d, input logic par,
                                              input logic [1:0] stops);
        int   ones;
        logic pe;
        logic fe;
        ones = $countones(d) + int'(par);
        if (PAR == 0)      pe = 1'b0;
        else if (PAR == 1) pe = (ones % 2) != 1;
        else               pe = (ones % 2) != 0;
        fe = (stops != 2'b11);
        return {d, pe, fe};
    endfunction

    task automatic expect_word(input logic [9:0] w);
        if (exp_q.size() >= DEPTH) exp_ovr = 1'b1;
        else exp_q.push_back(w);
    endtask

    task automatic wait_clks(input int n);
        if (n > 0) repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int nbits);
        rxd = b;
        wait_clks(nbits * BIT_CLK);
    endtask

    task automatic frame_body(input logic [7:0] d, input logic par);
        drive_bit(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 1);
        drive_bit(par, 1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic [1:0] stops, input int gap);
        expect_word(model_word(d, par, stops));
        frame_body(d, par);
        drive_bit(stops[0], 1);
        drive_bit(stops[1], 1);
        rxd = 1'b1;
        wait_clks(gap);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || rx_valid) && k < 4000) begin
            @(posedge clk);
            k++;
        end
        #1;
        n_cmp++;
        if (k >= 4000) begin
            n_bad++;
            $display("FAIL drain: %0d words still expected, rx_valid=%0d, required 0/0",
                     exp_q.size(), rx_valid);
            exp_q.delete();
        end
    endtask

    // Consumer ready: held low, held high, or random per cycle.
    initial begin
        rx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       rx_ready = 1'b0;
                1:       rx_ready = 1'b1;
                default: rx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every accepted word is checked against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && !prev_valid) rise_cyc = cyc;
            if (rx_valid && rx_ready) begin
                logic [9:0] e;
                n_cmp++;
                n_pops++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_word: got data=%02h perr=%0d ferr=%0d, required none",
                             rx_data, rx_perr, rx_ferr);
                end else begin
                    e = exp_q.pop_front();
                    if ({rx_data, rx_perr, rx_ferr} !== e) begin
                        n_bad++;
                        $display("FAIL word: got data=%02h perr=%0d ferr=%0d, required data=%02h perr=%0d ferr=%0d",
                                 rx_data, rx_perr, rx_ferr, e[9:2], e[1], e[0]);
                    end
                end
            end
        end
        prev_valid = rx_valid;
    end

    initial begin
        int         t0;
        int         lat;
        int         pops0;
        logic [7:0] d;
        logic [1:0] st;
        logic       par;
        int         gap;
        logic [7:0] d5a;

        rst_n       = 1'b0;
        rxd         = 1'b1;
        overrun_clr = 1'b0;
        wait_clks(5);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_perr", rx_perr, 0);
        check("rst_ferr", rx_ferr, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clk) rst_n = 1'b1;
        wait_clks(10);

        // 0xA5 with correct parity; rx_valid should rise just after mid stop-bit 2.
        ready_mode = 0;
        rise_cyc   = -1;
        t0         = cyc;
        send_frame(8'hA5, ^8'hA5, 2'b11, 20);
        check("a5_valid", rx_valid, 1);
        lat = rise_cyc - t0;
        n_cmp++;
        if (lat < 550 || lat > 564) begin
            n_bad++;
            $display("FAIL a5_latency: got %0d clocks, required 550..564", lat);
        end
        ready_mode = 1;
        drain();

        // Even parity: 0x03 with parity bit 1 is an error, with 0 it is clean.
        send_frame(8'h03, 1'b1, 2'b11, 10);
        send_frame(8'h03, 1'b0, 2'b11, 10);
        drain();

        // Short low glitch on an idle line is rejected.
        ready_mode = 0;
        rxd = 1'b0;
        wait_clks(4 * DIV);
        rxd = 1'b1;
        wait_clks(3 * BIT_CLK);
        check("glitch_valid", rx_valid, 0);
        ready_mode = 1;
        send_frame(8'h96, ^8'h96, 2'b11, 10);
        drain();

        // Low stop bits followed by a held-low line: exactly one ferr word.
        pops0 = n_pops;
        expect_word(model_word(8'h3C, ^8'h3C, 2'b00));
        frame_body(8'h3C, ^8'h3C);
        drive_bit(1'b0, 2);
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 2);
        drain();
        check("break_pops", n_pops - pops0, 1);
        send_frame(8'h7E, ^8'h7E, 2'b11, 10);
        drain();

        // Overrun: five frames into a four-deep FIFO with no consumer.
        ready_mode = 0;
        for (int i = 0; i < 5; i++) begin
            d = 8'h11 + 8'(i);
            send_frame(d, ^d, 2'b11, 10);
            if (i == 3) check("ovr_before", overrun, 0);
        end
        check("ovr_set", overrun, int'(exp_ovr));
        check("ovr_valid", rx_valid, 1);
        check("ovr_head", rx_data, 8'h11);
        ready_mode = 1;
        drain();
        check("ovr_sticky", overrun, int'(exp_ovr));
        overrun_clr = 1'b1;
        wait_clks(1);
        overrun_clr = 1'b0;
        exp_ovr     = 1'b0;
        check("ovr_clr", overrun, 0);

        // Random traffic with a random consumer.
        ready_mode = 2;
        for (int i = 0; i < 24; i++) begin
            d   = 8'($urandom_range(0, 255));
            par = (^d) ^ ($urandom_range(0, 3) == 0);
            st  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            gap = (st != 2'b11) ? int'(BIT_CLK) + int'($urandom_range(0, 20))
                                : int'($urandom_range(0, 20));
            send_frame(d, par, st, gap);
        end
        drain();
        check("rand_overrun", overrun, int'(exp_ovr));

        // Reset in the middle of 0x5A while the FIFO holds a word.
        ready_mode = 0;
        send_frame(8'h81, ^8'h81, 2'b11, 10);
        check("pre_rst_valid", rx_valid, 1);
        d5a = 8'h5A;
        drive_bit(1'b0, 1);
        for (int i = 0; i < 4; i++) drive_bit(d5a[i], 1);
        wait_clks(BIT_CLK / 2);
        rst_n = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
        wait_clks(3);
        check("midrst_valid", rx_valid, 0);
        check("midrst_data", rx_data, 0);
        check("midrst_perr", rx_perr, 0);
        check("midrst_ferr", rx_ferr, 0);
        check("midrst_overrun", overrun, 0);
        rxd = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        wait_clks(2 * BIT_CLK);
        ready_mode = 1;
        pops0 = n_pops;
        send_frame(8'hC3, ^8'hC3, 2'b11, 10);
        drain();
        check("c3_pops", n_pops - pops0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
